mac_controller: RTL and testbench

Control FSM for the 4-bit-operand, 12-bit-accumulator MAC datapath. It accepts operand pairs from an upstream source over a valid/ready handshake and sequences the datapath's load strobes (operand load, multiply register, accumulate, count, output). After N_TERMS products it commits the accumulator to the datapath output and reports completion. It sits between the operand source and the datapath and also owns the datapath's per-operation clear.

---
 rtl/mac_pkg.sv | 47 ++++
 rtl/mac_controller_if.sv | 45 ++++
 rtl/mac_term_counter.sv | 48 ++++
 rtl/mac_controller.sv | 211 +++++++++++++++++++++
 tb/tb_mac_controller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC datapath controller:
//   - FSM state encodings and the state enum
//   - default term count and counter width
//   - terminal-compare wait limit (used when MAC_CTRL_CMP_CHECK_EN is defined)
//   - elaboration helper that checks that N_TERMS fits in the term counter
// No ports (package).
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int N_TERMS_DEFAULT = 10;
  localparam int CNT_W_DEFAULT   = 4;

  // Cycles spent waiting for the datapath terminal-count flag before the
  // operation is abandoned with err set.
  localparam int CMP_WAIT_LIMIT = 4;
  localparam int CMP_WAIT_W     = 2;

  localparam logic [3:0] ST_IDLE_ENC      = 4'd0;
  localparam logic [3:0] ST_CLEAR_ENC     = 4'd1;
  localparam logic [3:0] ST_FETCH_ENC     = 4'd2;
  localparam logic [3:0] ST_MUL_ENC       = 4'd3;
  localparam logic [3:0] ST_ACC_ENC       = 4'd4;
  localparam logic [3:0] ST_CHECK_ENC     = 4'd5;
  localparam logic [3:0] ST_CMP_WAIT_ENC  = 4'd6;
  localparam logic [3:0] ST_OUT_ENC       = 4'd7;
  localparam logic [3:0] ST_WAIT_DONE_ENC = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_CLEAR     = ST_CLEAR_ENC,
    ST_FETCH     = ST_FETCH_ENC,
    ST_MUL       = ST_MUL_ENC,
    ST_ACC       = ST_ACC_ENC,
    ST_CHECK     = ST_CHECK_ENC,
    ST_CMP_WAIT  = ST_CMP_WAIT_ENC,
    ST_OUT       = ST_OUT_ENC,
    ST_WAIT_DONE = ST_WAIT_DONE_ENC
  } state_t;

  // N_TERMS must be reachable by a w-bit counter without wrapping.
  function automatic bit n_terms_legal(input int n, input int w);
    return (n >= 1) && (n <= ((2 ** w) - 1));
  endfunction

endpackage

// File: rtl/mac_controller_if.sv
// ---------------------------------------------------------------------------
// mac_controller_if
// Handshake and strobe bundle between the MAC controller, the operand
// source and the MAC datapath.
//   slave  modport : the controller (consumes start/in_valid/cmp/done,
//                    drives ready, strobes and status)
//   master modport : the environment (operand source + datapath)
// Signals:
//   start, in_valid, cmp, done           environment -> controller
//   in_ready, load_a, load_b, load_m,
//   load_acc, count_enable, load_out,
//   dp_rst, busy, result_valid, err      controller  -> environment
// ---------------------------------------------------------------------------
interface mac_controller_if;

  logic start;
  logic in_valid;
  logic cmp;
  logic done;

  logic in_ready;
  logic load_a;
  logic load_b;
  logic load_m;
  logic load_acc;
  logic count_enable;
  logic load_out;
  logic dp_rst;
  logic busy;
  logic result_valid;
  logic err;

  modport slave (
    input  start, in_valid, cmp, done,
    output in_ready, load_a, load_b, load_m, load_acc, count_enable,
           load_out, dp_rst, busy, result_valid, err
  );

  modport master (
    output start, in_valid, cmp, done,
    input  in_ready, load_a, load_b, load_m, load_acc, count_enable,
           load_out, dp_rst, busy, result_valid, err
  );

endinterface

// File: rtl/mac_term_counter.sv
// ---------------------------------------------------------------------------
// mac_term_counter
// CNT_W-bit term counter with synchronous clear, increment and a terminal
// compare against N_TERMS. The counter saturates at all-ones so it can never
// wrap back to a value that would fake an early terminal match.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   clr   in  clear counter to zero (wins over inc)
//   inc   in  increment counter
//   at_n  out counter currently equals N_TERMS
// ---------------------------------------------------------------------------
module mac_term_counter #(
  parameter int CNT_W   = 4,
  parameter int N_TERMS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_n
);

  localparam logic [CNT_W-1:0] TERM_LAST = CNT_W'(N_TERMS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_n = (cnt_q == TERM_LAST);

endmodule

// File: rtl/mac_controller.sv
// ---------------------------------------------------------------------------
// mac_controller
// Control FSM for the 4-bit-operand / 12-bit-accumulator MAC datapath.
// Accepts operand pairs over a valid/ready handshake, sequences the datapath
// strobes (operand load, multiply, accumulate+count, output commit) and,
// after N_TERMS products, commits the sum and pulses result_valid once the
// datapath reports done. It also owns the datapath's per-operation clear.
//
// Parameters:
//   N_TERMS  products per operation (1 .. 2**CNT_W-1, checked at elaboration)
//   CNT_W    term counter width
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of mac_controller_if (handshake, strobes, status)
//
// Build option: MAC_CTRL_CMP_CHECK_EN
//   defined   : after the last term the controller waits (up to
//               CMP_WAIT_LIMIT cycles) for the datapath terminal-count flag
//               cmp; if it never arrives err is set and the operation is
//               abandoned without committing the output.
//   undefined : cmp is ignored and err is tied low.
// ---------------------------------------------------------------------------
module mac_controller
  import mac_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  mac_controller_if.slave bus
);

  if (!n_terms_legal(N_TERMS, CNT_W)) begin : g_bad_n_terms
    $error("mac_controller: N_TERMS=%0d does not fit CNT_W=%0d", N_TERMS, CNT_W);
  end

  state_t state_q;
  state_t state_d;

  // Moore outputs are registered from the next state so they change
  // cleanly on the clock edge and drop immediately on rst.
  logic in_ready_q,     in_ready_d;
  logic load_m_q,       load_m_d;
  logic load_acc_q,     load_acc_d;
  logic count_enable_q, count_enable_d;
  logic load_out_q,     load_out_d;
  logic dp_rst_q,       dp_rst_d;
  logic busy_q,         busy_d;

  logic cnt_clr;
  logic cnt_inc;
  logic term_done;

  mac_term_counter #(
    .CNT_W   (CNT_W),
    .N_TERMS (N_TERMS)
  ) u_term_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .at_n (term_done)
  );

`ifdef MAC_CTRL_CMP_CHECK_EN
  localparam logic [CMP_WAIT_W-1:0] CMP_WAIT_LAST = CMP_WAIT_W'(CMP_WAIT_LIMIT - 1);

  logic [CMP_WAIT_W-1:0] wait_q;
  logic [CMP_WAIT_W-1:0] wait_d;
  logic                  err_q;
  logic                  err_d;
`else
  logic unused_cmp;
  assign unused_cmp = bus.cmp;
`endif

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef MAC_CTRL_CMP_CHECK_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CLEAR;
          cnt_clr = 1'b1;
`ifdef MAC_CTRL_CMP_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end

      ST_CLEAR: state_d = ST_FETCH;

      ST_FETCH: begin
        if (bus.in_valid) begin
          state_d = ST_MUL;
        end
      end

      ST_MUL: state_d = ST_ACC;

      ST_ACC: begin
        cnt_inc = 1'b1;
        state_d = ST_CHECK;
      end

      // term_cnt was bumped on the ACC edge, so the compare here already
      // reflects the term that just finished.
      ST_CHECK: begin
        if (term_done) begin
`ifdef MAC_CTRL_CMP_CHECK_EN
          state_d = ST_CMP_WAIT;
          wait_d  = '0;
`else
          state_d = ST_OUT;
`endif
        end else begin
          state_d = ST_FETCH;
        end
      end

`ifdef MAC_CTRL_CMP_CHECK_EN
      ST_CMP_WAIT: begin
        if (bus.cmp) begin
          state_d = ST_OUT;
        end else if (wait_q == CMP_WAIT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
`endif

      ST_OUT: state_d = ST_WAIT_DONE;

      ST_WAIT_DONE: begin
        if (bus.done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d     = (state_d == ST_FETCH);
    load_m_d       = (state_d == ST_MUL);
    load_acc_d     = (state_d == ST_ACC);
    count_enable_d = (state_d == ST_ACC);
    load_out_d     = (state_d == ST_OUT);
    // Dedicated flop: the datapath ORs this into its async reset, so it
    // must never glitch the way a state decode could.
    dp_rst_d       = (state_d == ST_CLEAR);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      in_ready_q     <= 1'b0;
      load_m_q       <= 1'b0;
      load_acc_q     <= 1'b0;
      count_enable_q <= 1'b0;
      load_out_q     <= 1'b0;
      dp_rst_q       <= 1'b0;
      busy_q         <= 1'b0;
`ifdef MAC_CTRL_CMP_CHECK_EN
      wait_q         <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      load_m_q       <= load_m_d;
      load_acc_q     <= load_acc_d;
      count_enable_q <= count_enable_d;
      load_out_q     <= load_out_d;
      dp_rst_q       <= dp_rst_d;
      busy_q         <= busy_d;
`ifdef MAC_CTRL_CMP_CHECK_EN
      wait_q         <= wait_d;
      err_q          <= err_d;
`endif
    end
  end

  assign bus.in_ready     = in_ready_q;
  // Operand load happens in the same cycle the source offers a pair.
  assign bus.load_a       = in_ready_q & bus.in_valid;
  assign bus.load_b       = in_ready_q & bus.in_valid;
  assign bus.load_m       = load_m_q;
  assign bus.load_acc     = load_acc_q;
  assign bus.count_enable = count_enable_q;
  assign bus.load_out     = load_out_q;
  assign bus.dp_rst       = dp_rst_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = (state_q == ST_WAIT_DONE) & bus.done;
`ifdef MAC_CTRL_CMP_CHECK_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_mac_controller.sv
// ---------------------------------------------------------------------------
// tb_mac_controller
// Drives mac_controller with a behavioural operand source and MAC datapath.
// Each operation's expected sum and result_valid latency are derived from
// the operand list and the number of stalled FETCH cycles, pushed into a
// scoreboard queue, and checked by an independent monitor on result_valid.
// ---------------------------------------------------------------------------
module tb_mac_controller;

  localparam int N  = 10;
  localparam int CW = 4;
`ifdef MAC_CTRL_CMP_CHECK_EN
  localparam int  EXTRA     = 1;
  localparam bit  CMP_CHECK = 1'b1;
`else
  localparam int  EXTRA     = 0;
  localparam bit  CMP_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_controller_if bus();

  mac_controller #(.N_TERMS(N), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- behavioural datapath ----------------
  logic [3:0]    dp_a_in, dp_b_in;
  logic [3:0]    ra, rb;
  logic [7:0]    rm;
  logic [11:0]   acc, dp_out;
  logic [CW-1:0] dcnt;
  logic          dp_done;
  bit            force_cmp0 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0; rb <= '0; rm <= '0; acc <= '0; dp_out <= '0; dcnt <= '0; dp_done <= 1'b0;
    end else if (bus.dp_rst) begin
      acc <= '0; dcnt <= '0; dp_done <= 1'b0;
    end else begin
      if (bus.load_a)       ra <= dp_a_in;
      if (bus.load_b)       rb <= dp_b_in;
      if (bus.load_m)       rm <= ra * rb;
      if (bus.load_acc)     acc <= acc + {4'd0, rm};
      if (bus.count_enable) dcnt <= dcnt + 1'b1;
      if (bus.load_out) begin
        dp_out  <= acc;
        dp_done <= 1'b1;
      end
    end
  end

  assign bus.cmp  = force_cmp0 ? 1'b0 : (dcnt == CW'(N));
  assign bus.done = dp_done;

  logic [10:0] outs;
  assign outs = {bus.in_ready, bus.load_a, bus.load_b, bus.load_m, bus.load_acc,
                 bus.count_enable, bus.load_out, bus.dp_rst, bus.busy,
                 bus.result_valid, bus.err};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int sum;
    int start_cyc;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   acc_pulses = 0;
  int   out_pulses = 0;
  int   extra_off = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      acc_pulses = 0;
      out_pulses = 0;
    end else begin
      if (bus.dp_rst) begin
        acc_pulses = 0;
        out_pulses = 0;
      end
      if (bus.load_acc) acc_pulses++;
      if (bus.load_out) out_pulses++;
      if (bus.load_a | bus.load_m | bus.load_acc | bus.load_out | bus.dp_rst) begin
        chk("strobe_onehot",
            $countones({bus.load_a, bus.load_m, bus.load_acc, bus.load_out, bus.dp_rst}), 1);
        chk("ab_pair", int'(bus.load_a), int'(bus.load_b));
        chk("acc_cnt_pair", int'(bus.load_acc), int'(bus.count_enable));
      end
      if (bus.result_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result_valid", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sum", int'(dp_out), mon_e.sum);
          chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
          chk("acc_pulses", acc_pulses, N);
          $display("txn result sum=%0d exp=%0d latency=%0d exp=%0d", dp_out, mon_e.sum,
                   cyc - mon_e.start_cyc, mon_e.lat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input bit rnd, input int fa, input int fb, input int max_stall,
                        input int stall_term, input int stall_len, input int xstart,
                        input bit cmp_fail);
    int   a[N];
    int   b[N];
    int   s[N];
    int   sum;
    int   tot;
    int   sc;
    int   w;
    exp_t e;
    sum = 0;
    tot = 0;
    for (int t = 0; t < N; t++) begin
      a[t] = rnd ? int'($urandom_range(15, 0)) : fa;
      b[t] = rnd ? int'($urandom_range(15, 0)) : fb;
      s[t] = (t == stall_term) ? stall_len :
             ((max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
      sum += a[t] * b[t];
      tot += s[t];
    end
    force_cmp0 = cmp_fail;

    @(negedge clk);
    bus.start = 1'b1;
    sc = cyc;
    if (!(cmp_fail && CMP_CHECK)) begin
      e.sum       = sum & 'hFFF;
      e.start_cyc = sc;
      e.lat       = 4 * N + 3 + tot + EXTRA;
      sb_q.push_back(e);
    end
    if (xstart > 0) begin
      extra_off = xstart;
      fork
        begin
          repeat (extra_off) @(negedge clk);
          bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
        end
      join_none
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("clear_dp_rst", int'(bus.dp_rst), 1);
    chk("clear_busy", int'(bus.busy), 1);
    chk("err_cleared_on_start", int'(bus.err), 0);

    for (int t = 0; t < N; t++) begin
      w = 0;
      while (!bus.in_ready && w < 64) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) begin
        chk("fetch_timeout", 0, 1);
        return;
      end
      for (int k = 0; k < s[t]; k++) begin
        bus.in_valid = 1'b0;
        #1;
        chk("stall_in_ready", int'(bus.in_ready), 1);
        chk("stall_no_strobe", int'(outs[9:4]), 0);
        @(negedge clk);
      end
      dp_a_in = 4'(a[t]);
      dp_b_in = 4'(b[t]);
      bus.in_valid = 1'b1;
      #1;
      chk("load_a_mealy", int'(bus.load_a), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end

    w = 0;
    while (bus.busy && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("busy_released", int'(bus.busy), 0);
    if (cmp_fail && CMP_CHECK) begin
      chk("cmp_timeout_cycles", cyc - sc, 4 * N + 6 + tot);
      chk("cmp_timeout_err", int'(bus.err), 1);
      chk("cmp_timeout_no_load_out", out_pulses, 0);
      $display("txn cmp timeout err=%0d cycles=%0d", bus.err, cyc - sc);
    end else begin
      chk("err_low", int'(bus.err), 0);
    end
    chk("sb_drained", sb_q.size(), 0);
    force_cmp0 = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    dp_a_in      = '0;
    dp_b_in      = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Baseline: A=3, B=5, no stalls.
    run_op(1'b0, 3, 5, 0, -1, 0, 0, 1'b0);
    // Three-cycle stall on term 4.
    run_op(1'b0, 3, 5, 0, 3, 3, 0, 1'b0);
    // start while busy is ignored; the following operation is independent.
    run_op(1'b0, 3, 5, 0, -1, 0, 20, 1'b0);
    run_op(1'b0, 3, 5, 0, -1, 0, 0, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start    = 1'b1;
    dp_a_in      = 4'd3;
    dp_b_in      = 4'd5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_before_rst", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 chk("rst_midop_outputs", int'(outs), 0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    run_op(1'b0, 3, 5, 0, -1, 0, 0, 1'b0);

    // cmp held low: timeout with the check enabled, ignored otherwise.
    run_op(1'b0, 3, 5, 0, -1, 0, 0, 1'b1);
    run_op(1'b0, 15, 15, 0, -1, 0, 0, 1'b0);

    // Random operands and random FETCH stalls.
    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, 0, 0, 2, -1, 0, 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
